keyed_prio_intr_ctrl: RTL and testbench
=======================================

Name: keyed_prio_intr_ctrl

Overview:
- Parametrised, registered, key-locked priority interrupt controller for NGRP request groups of NCH channels each. It is the sequential successor of the fixed 27-channel combinational interrupt encoder.
- Requests are latched as sticky pending bits and arbitrated by fixed priority. Each grant is held until it is acknowledged.
- Reported group/channel numbers are XOR-corrupted by a key mismatch mask until the correct key is shifted in and committed.
- Repeated wrong commits permanently block the block until reset.

Parameters:
- NCH, 9, channels per group (>=2).
- NGRP, 3, number of groups (>=2); group 0 has highest priority.
- KEY_W, 16, key length in bits; must be >= CH_W+GRP_W.
- KEY_VAL, 16'hA5C3, correct unlock key.
- MAX_FAIL, 3, wrong commits before BLOCKED.
- Derived: CH_W = clog2(NCH); GRP_W = max(1, clog2(NGRP)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NGRP*NCH  request pulses/levels; bit index g*NCH+c.
- grp_en  in  NGRP  per-group arbitration enable.
- ack  in  1  clear the pending bit selected by ack_grp/ack_chan.
- ack_grp  in  GRP_W  group to acknowledge.
- ack_chan  in  CH_W  channel to acknowledge.
- key_shift  in  1  shift key_bit into the key register.
- key_bit  in  1  serial key bit.
- key_commit  in  1  compare the key register against KEY_VAL.
- irq_valid  out  1  a grant is present.
- irq_grp  out  GRP_W  granted group (possibly corrupted).
- irq_chan  out  CH_W  granted channel (possibly corrupted).
- unlocked  out  1  FSM in UNLOCKED.
- blocked  out  1  FSM in BLOCKED.

Behaviour:
- Reset (synchronous, active-high):
  - pending=0, key_q=0, fail_cnt=0, FSM=LOCKED.
  - irq_valid=0, irq_grp=0, irq_chan=0, unlocked=0, blocked=0.
- Pending bits:
  - pending_d = (pending_q & ~ack_mask) | req.
  - ack_mask is one-hot at ack_grp*NCH+ack_chan when ack=1.
  - An out-of-range ack index is ignored.
  - Simultaneous set and clear on the same bit: set wins.
- Arbitration uses pending_d masked by grp_en:
  - lowest enabled group with any pending bit wins;
  - within that group, the lowest channel index wins.
  - Disabled groups keep their pending bits.
- Outputs are registered from the arbitration result, so latency is 1 cycle: req asserted at edge t gives irq_* valid after edge t.
- Output encoding:
  - irq_valid = any masked pending bit, and FSM != BLOCKED.
  - True grant values are tg and tc. When irq_valid=0, the true values are tg=0 and tc=0.
  - corr = key_q ^ KEY_VAL.
  - irq_chan = tc ^ corr[CH_W-1:0].
  - irq_grp = tg ^ corr[CH_W+GRP_W-1:CH_W].
  - In UNLOCKED, irq_chan=tc and irq_grp=tg.
  - In LOCKED, the XOR corruption is applied even when it happens to be zero.
  - In BLOCKED, irq_valid=0, irq_grp=0, irq_chan=0.
- Key register:
  - key_shift: key_q <= {key_q[KEY_W-2:0], key_bit}, MSB first.
  - Shifting is allowed in LOCKED and UNLOCKED and ignored in BLOCKED.
  - Shifting does not change FSM state.
- FSM states: LOCKED, UNLOCKED, BLOCKED. The FSM acts on key_commit:
  - The comparison uses key_q before any same-cycle shift; that shift still occurs.
  - Match: next state UNLOCKED, fail_cnt=0.
  - Mismatch with fail_cnt+1 == MAX_FAIL: next state BLOCKED.
  - Other mismatch: next state LOCKED, fail_cnt += 1. This applies from UNLOCKED too (relock).
  - In BLOCKED, commits are ignored; only rst exits.
- Register timing: unlocked and blocked are registered state decodes, so they change one cycle after the commit. irq_* use the new state from the next output update onward.
- The pending and arbitration paths keep running in every state. Blocking only masks the outputs, and pending bits survive a lock transition.
- Reset mid-shift or mid-grant returns everything to reset values.

Test Plan:
All scenarios use the default parameters: CH_W=4, GRP_W=2, KEY_VAL=16'hA5C3.
1. Locked corruption:
   - Stimulus: after reset, pulse req bit 2 (grp0 ch2); grp_en=3'b111.
   - Response: next cycle irq_valid=1, irq_chan=2^3=1, irq_grp=0^0=0, unlocked=0.
2. Unlock:
   - Stimulus: shift 16 bits of 16'hA5C3 MSB first, pulse key_commit.
   - Response: unlocked=1 next cycle; the pending grp0 ch2 then reads irq_grp=0, irq_chan=2.
3. Priority and group enable:
   - Stimulus (unlocked): pulse req bits 14 (grp1 ch5) and 9 (grp1 ch0) with grp0 empty.
   - Response: grant grp1 ch0.
   - Stimulus: add req bit 20 (grp2 ch2) and set grp_en=3'b101.
   - Response: grant grp2 ch2. Restoring grp_en=3'b111 returns the grant to grp1 ch0.
4. Acknowledge:
   - Stimulus: ack grp1 ch0.
   - Response: next grant grp1 ch5.
   - Stimulus: ack grp1 ch5 in the same cycle as req bit 14.
   - Response: the bit stays pending and the grant remains grp1 ch5.
   - Stimulus: ack all bits.
   - Response: irq_valid=0, irq_grp=0, irq_chan=0.
5. Blocking:
   - Stimulus: from reset, commit the wrong key 16'h0000 three times.
   - Response: blocked=1 after the third commit. With any req, irq_valid stays 0. Shifting and committing 16'hA5C3 still gives blocked=1 and unlocked=0.
   - Stimulus: assert rst.
   - Response: all outputs 0.
6. Relock and shift/commit overlap:
   - Stimulus: in UNLOCKED, commit a mismatching key.
   - Response: unlocked=0 and fail_cnt=1.
   - Stimulus: key_shift together with key_commit while key_q=16'hA5C3.
   - Response: the commit matches (pre-shift value) and key_q holds the shifted value.

Source files
------------

// File: rtl/keyed_prio_intr_ctrl.sv
// Key-locked, fixed-priority interrupt controller with sticky pending bits.
// The reported group/channel are XOR-scrambled until the correct key is committed.
module keyed_prio_intr_ctrl #(
    parameter int NCH = 9,
    parameter int NGRP = 3,
    parameter int KEY_W = 16,
    parameter logic [KEY_W-1:0] KEY_VAL = 16'hA5C3,
    parameter int MAX_FAIL = 3,
    localparam int CH_W = $clog2(NCH),
    localparam int GRP_W = ($clog2(NGRP) > 1) ? $clog2(NGRP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NGRP*NCH-1:0]  req,
    input  logic [NGRP-1:0]      grp_en,
    input  logic                 ack,
    input  logic [GRP_W-1:0]     ack_grp,
    input  logic [CH_W-1:0]      ack_chan,
    input  logic                 key_shift,
    input  logic                 key_bit,
    input  logic                 key_commit,
    output logic                 irq_valid,
    output logic [GRP_W-1:0]     irq_grp,
    output logic [CH_W-1:0]      irq_chan,
    output logic                 unlocked,
    output logic                 blocked
);
    localparam int NREQ = NGRP * NCH;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {LOCKED, UNLOCKED, BLOCKED} state_t;

    state_t             state_reg, state_next;
    logic [FAIL_W-1:0]  fail_reg, fail_next;
    logic [KEY_W-1:0]   key_reg, key_next;
    logic [NREQ-1:0]    pending_reg, pending_next;
    logic [NREQ-1:0]    ack_mask, masked;
    logic               found;
    logic [GRP_W-1:0]   tg;
    logic [CH_W-1:0]    tc;
    logic               irq_valid_reg, irq_valid_next;
    logic [GRP_W-1:0]   irq_grp_reg, irq_grp_next;
    logic [CH_W-1:0]    irq_chan_reg, irq_chan_next;
    logic [CH_W-1:0]    corr_chan;
    logic [GRP_W-1:0]   corr_grp;

    // Decoding against every in-range index means out-of-range acks match nothing.
    genvar gi, ci;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            for (ci = 0; ci < NCH; ci++) begin : g_ch
                assign ack_mask[gi*NCH+ci] = ack && (ack_grp == GRP_W'(gi)) && (ack_chan == CH_W'(ci));
            end
            assign masked[gi*NCH +: NCH] = pending_next[gi*NCH +: NCH] & {NCH{grp_en[gi]}};
        end
    endgenerate

    assign pending_next = (pending_reg & ~ack_mask) | req;

    // Group-major scan: first hit is the lowest enabled group, lowest channel.
    always_comb begin
        found = 1'b0;
        tg    = '0;
        tc    = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!found && masked[g*NCH+c]) begin
                    found = 1'b1;
                    tg    = GRP_W'(g);
                    tc    = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        fail_next  = fail_reg;
        key_next   = key_reg;
        if (state_reg != BLOCKED) begin
            if (key_shift)
                key_next = {key_reg[KEY_W-2:0], key_bit};
            if (key_commit) begin
                if (key_reg == KEY_VAL) begin
                    state_next = UNLOCKED;
                    fail_next  = '0;
                end else if (fail_reg + FAIL_W'(1) == FAIL_W'(MAX_FAIL)) begin
                    state_next = BLOCKED;
                    fail_next  = fail_reg + FAIL_W'(1);
                end else begin
                    state_next = LOCKED;
                    fail_next  = fail_reg + FAIL_W'(1);
                end
            end
        end
    end

    assign corr_chan = key_reg[CH_W-1:0] ^ KEY_VAL[CH_W-1:0];
    assign corr_grp  = key_reg[CH_W+GRP_W-1:CH_W] ^ KEY_VAL[CH_W+GRP_W-1:CH_W];

    // Outputs use the state and key as they stand at this edge.
    always_comb begin
        irq_valid_next = found && (state_reg != BLOCKED);
        irq_grp_next   = '0;
        irq_chan_next  = '0;
        case (state_reg)
            UNLOCKED: begin
                irq_grp_next  = tg;
                irq_chan_next = tc;
            end
            LOCKED: begin
                irq_grp_next  = tg ^ corr_grp;
                irq_chan_next = tc ^ corr_chan;
            end
            default: begin
                irq_grp_next  = '0;
                irq_chan_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOCKED;
            fail_reg      <= '0;
            key_reg       <= '0;
            pending_reg   <= '0;
            irq_valid_reg <= 1'b0;
            irq_grp_reg   <= '0;
            irq_chan_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            fail_reg      <= fail_next;
            key_reg       <= key_next;
            pending_reg   <= pending_next;
            irq_valid_reg <= irq_valid_next;
            irq_grp_reg   <= irq_grp_next;
            irq_chan_reg  <= irq_chan_next;
        end
    end

    assign irq_valid = irq_valid_reg;
    assign irq_grp   = irq_grp_reg;
    assign irq_chan  = irq_chan_reg;
    assign unlocked  = (state_reg == UNLOCKED);
    assign blocked   = (state_reg == BLOCKED);
endmodule

// File: tb/tb_keyed_prio_intr_ctrl.sv
module tb_keyed_prio_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] req = '0;
    logic [2:0]  grp_en = '0;
    logic        ack = 1'b0;
    logic [1:0]  ack_grp = '0;
    logic [3:0]  ack_chan = '0;
    logic        key_shift = 1'b0;
    logic        key_bit = 1'b0;
    logic        key_commit = 1'b0;
    logic        irq_valid;
    logic [1:0]  irq_grp;
    logic [3:0]  irq_chan;
    logic        unlocked;
    logic        blocked;

    keyed_prio_intr_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .grp_en(grp_en),
        .ack(ack), .ack_grp(ack_grp), .ack_chan(ack_chan),
        .key_shift(key_shift), .key_bit(key_bit), .key_commit(key_commit),
        .irq_valid(irq_valid), .irq_grp(irq_grp), .irq_chan(irq_chan),
        .unlocked(unlocked), .blocked(blocked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0] req;
        logic [2:0]  en;
        logic        ack;
        logic [1:0]  ag;
        logic [3:0]  ac;
        logic        ks;
        logic        kb;
        logic        kc;
        logic        rs;
        logic        chk;
        logic [8:0]  exp;
    } vec_t;

    vec_t        tbl[$];
    string       nms[$];
    logic [8:0]  sb_exp[$];
    string       sb_nm[$];
    int          checks = 0;
    int          failures = 0;
    logic        done = 1'b0;

    function automatic logic [8:0] e(logic v, logic [1:0] g, logic [3:0] c, logic u, logic b);
        return {v, g, c, u, b};
    endfunction

    task automatic add(string nm, logic [26:0] r, logic [2:0] en, logic a, logic [1:0] ag,
                       logic [3:0] ac, logic ks, logic kb, logic kc, logic rs, logic chk,
                       logic [8:0] ex);
        vec_t v;
        v.req = r; v.en = en; v.ack = a; v.ag = ag; v.ac = ac;
        v.ks = ks; v.kb = kb; v.kc = kc; v.rs = rs; v.chk = chk; v.exp = ex;
        tbl.push_back(v);
        nms.push_back(nm);
    endtask

    task automatic add_shift(logic [15:0] val, logic chk, logic [8:0] ex);
        for (int i = 15; i >= 0; i--)
            add("shift", '0, 3'b111, 1'b0, 2'd0, 4'd0, 1'b1, val[i], 1'b0, 1'b0, chk, ex);
    endtask

    task automatic idle(string nm, logic [2:0] en, logic [8:0] ex);
        add(nm, '0, en, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex);
    endtask

    task automatic do_ack(string nm, logic [26:0] r, logic [1:0] ag, logic [3:0] ac, logic [8:0] ex);
        add(nm, r, 3'b111, 1'b1, ag, ac, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex);
    endtask

    task automatic commit(string nm, logic [26:0] r, logic ks, logic kb, logic [8:0] ex);
        add(nm, r, 3'b111, 1'b0, 2'd0, 4'd0, ks, kb, 1'b1, 1'b0, 1'b1, ex);
    endtask

    task automatic do_rst(string nm);
        add(nm, '0, 3'b111, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e(0, 0, 0, 0, 0));
    endtask

    initial begin
        #100000;
        if (!done) begin
            failures++;
            $display("FAIL timeout: stimulus did not complete in time");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        do_rst("reset");
        idle("locked_idle", 3'b111, e(0, 0, 3, 0, 0));
        add("locked_req_g0c2", 27'h4, 3'b111, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(1, 0, 1, 0, 0));
        idle("locked_hold", 3'b111, e(1, 0, 1, 0, 0));
        add_shift(16'hA5C3, 1'b0, '0);
        commit("unlock_commit", '0, 1'b0, 1'b0, e(1, 0, 2, 1, 0));
        idle("unlocked_g0c2", 3'b111, e(1, 0, 2, 1, 0));
        do_ack("ack_g0c2", '0, 2'd0, 4'd2, e(0, 0, 0, 1, 0));
        add("req_g1c5_g1c0", 27'h4200, 3'b111, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(1, 1, 0, 1, 0));
        idle("grp1_disabled", 3'b001, e(0, 0, 0, 1, 0));
        add("req_g2c2_en101", 27'h100000, 3'b101, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(1, 2, 2, 1, 0));
        idle("en_restored", 3'b111, e(1, 1, 0, 1, 0));
        do_ack("ack_g1c0", '0, 2'd1, 4'd0, e(1, 1, 5, 1, 0));
        do_ack("ack_set_wins", 27'h4000, 2'd1, 4'd5, e(1, 1, 5, 1, 0));
        do_ack("ack_g1c5", '0, 2'd1, 4'd5, e(1, 2, 2, 1, 0));
        do_ack("ack_chan_oor", '0, 2'd1, 4'd11, e(1, 2, 2, 1, 0));
        do_ack("ack_grp_oor", '0, 2'd3, 4'd2, e(1, 2, 2, 1, 0));
        do_ack("ack_g2c2", '0, 2'd2, 4'd2, e(0, 0, 0, 1, 0));
        commit("shift_commit", 27'h1, 1'b1, 1'b0, e(1, 0, 0, 1, 0));
        commit("relock", '0, 1'b0, 1'b0, e(1, 0, 0, 0, 0));
        idle("relocked_scramble", 3'b111, e(1, 0, 5, 0, 0));
        commit("wrong2", '0, 1'b0, 1'b0, e(1, 0, 5, 0, 0));
        commit("wrong3_block", '0, 1'b0, 1'b0, e(1, 0, 5, 0, 1));
        idle("blocked_idle", 3'b111, e(0, 0, 0, 0, 1));
        do_rst("reset2");
        commit("zero_key1", '0, 1'b0, 1'b0, e(0, 0, 3, 0, 0));
        commit("zero_key2", '0, 1'b0, 1'b0, e(0, 0, 3, 0, 0));
        commit("zero_key3", '0, 1'b0, 1'b0, e(0, 0, 3, 0, 1));
        add("blocked_req", 27'h20, 3'b111, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 0, 1));
        add_shift(16'hA5C3, 1'b1, e(0, 0, 0, 0, 1));
        commit("blocked_good_key", '0, 1'b0, 1'b0, e(0, 0, 0, 0, 1));
        idle("still_blocked", 3'b111, e(0, 0, 0, 0, 1));
        do_rst("reset_from_blocked");
        idle("after_reset_clean", 3'b111, e(0, 0, 3, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            req = tbl[i].req; grp_en = tbl[i].en; ack = tbl[i].ack;
            ack_grp = tbl[i].ag; ack_chan = tbl[i].ac;
            key_shift = tbl[i].ks; key_bit = tbl[i].kb; key_commit = tbl[i].kc;
            rst = tbl[i].rs;
            if (tbl[i].chk) begin
                sb_exp.push_back(tbl[i].exp);
                sb_nm.push_back(nms[i]);
            end
            @(posedge clk);
            #1;
            if (tbl[i].rs) begin
                checks++;
                if ({irq_valid, irq_grp, irq_chan, unlocked, blocked} !== 9'd0) begin
                    failures++;
                    $display("FAIL %s reset state: v=%b g=%0d c=%0d u=%b b=%b, expected all 0",
                             nms[i], irq_valid, irq_grp, irq_chan, unlocked, blocked);
                end
            end
            if (tbl[i].chk) begin
                logic [8:0] got, want;
                string nm;
                want = sb_exp.pop_front();
                nm = sb_nm.pop_front();
                got = {irq_valid, irq_grp, irq_chan, unlocked, blocked};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s: got v=%b g=%0d c=%0d u=%b b=%b, expected v=%b g=%0d c=%0d u=%b b=%b",
                             nm, got[8], got[7:6], got[5:2], got[1], got[0],
                             want[8], want[7:6], want[5:2], want[1], want[0]);
                end else begin
                    $display("txn %0d %s v=%b g=%0d c=%0d u=%b b=%b",
                             i, nm, got[8], got[7:6], got[5:2], got[1], got[0]);
                end
            end
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
